// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ONESHOT  = 2'b00,
        RETRIG   = 2'b01,
        PERIODIC = 2'b10,
        RSVD     = 2'b11
    } pg_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } pg_state_e;

    localparam int PG_MODE_W = 2;

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse generator channel: trigger edge detect, three-state FSM and
// down-counter that times both the HIGH and LOW phases.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a trigger event; outputs low
// HIGH  | pulse_out asserted, cnt counts down the remaining high cycles
// LOW   | periodic mode only: low half of the period, cnt counts it down
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int EDGE_TRIG = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    input  logic [PG_MODE_W-1:0] cfg_mode,
    input  logic                 trig,
    input  logic                 stop,
    output logic                 pulse_out,
    output logic                 busy,
    output logic                 done
);

    pg_state_e            state_q, state_d;
    pg_mode_e             mode_q, mode_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 trig_q;
    logic                 ev;
    logic                 done_d;

    // trig_q resets high so a trigger held across reset release is not an edge
    assign ev = (EDGE_TRIG != 0) ? (trig & ~trig_q) : trig;

    // State, counter, snapshot and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= ONESHOT;
            cnt_q     <= '0;
            len_q     <= '0;
            trig_q    <= 1'b1;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            trig_q    <= trig;
            pulse_out <= (state_d == HIGH);
            busy      <= (state_d != IDLE);
            done      <= done_d;
        end
    end

    // Next-state logic; stop overrides events and natural completion
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero-length request is dropped silently
                    if (ev && (cfg_len != '0)) begin
                        state_d = HIGH;
                        cnt_d   = cfg_len - CNT_WIDTH'(1);
                        len_d   = cfg_len;
                        mode_d  = pg_mode_e'(cfg_mode);
                    end
                end
                HIGH: begin
                    if (ev && (mode_q == RETRIG)) begin
                        cnt_d = len_q - CNT_WIDTH'(1);
                    end else if (cnt_q == '0) begin
                        if (mode_q == PERIODIC) begin
                            state_d = LOW;
                            cnt_d   = len_q - CNT_WIDTH'(1);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
                LOW: begin
                    if (cnt_q == '0) begin
                        state_d = HIGH;
                        cnt_d   = len_q - CNT_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: slices the configuration and control
// buses and hands each slice to an independent channel.
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_WIDTH = 8,
    parameter int EDGE_TRIG = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CH*CNT_WIDTH-1:0] cfg_len,
    input  logic [N_CH*PG_MODE_W-1:0] cfg_mode,
    input  logic [N_CH-1:0]           trig,
    input  logic [N_CH-1:0]           stop,
    output logic [N_CH-1:0]           pulse_out,
    output logic [N_CH-1:0]           busy,
    output logic [N_CH-1:0]           done
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_gen_ch #(
            .CNT_WIDTH (CNT_WIDTH),
            .EDGE_TRIG (EDGE_TRIG)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .cfg_len   (cfg_len[i*CNT_WIDTH +: CNT_WIDTH]),
            .cfg_mode  (cfg_mode[i*PG_MODE_W +: PG_MODE_W]),
            .trig      (trig[i]),
            .stop      (stop[i]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: per-cycle expected outputs are derived from
// the pulse timing rules, queued as stimulus is driven, and compared once
// the clock edge has produced the outputs.
module tb_pulse_gen_multi;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] cfg_len;
    logic [2*N-1:0] cfg_mode;
    logic [N-1:0]   trig;
    logic [N-1:0]   stop;
    logic [N-1:0]   pulse_out;
    logic [N-1:0]   busy;
    logic [N-1:0]   done;

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] d;
        logic [N-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pulse_gen_multi #(.N_CH(N), .CNT_WIDTH(W), .EDGE_TRIG(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_len   (cfg_len),
        .cfg_mode  (cfg_mode),
        .trig      (trig),
        .stop      (stop),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(int ch, bit v);
        logic [N-1:0] r;
        r     = '0;
        r[ch] = v;
        return r;
    endfunction

    task automatic push_exp(logic [N-1:0] p, logic [N-1:0] d, logic [N-1:0] b);
        exp_t e;
        e.p = p;
        e.d = d;
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        bit   pe;
        // outputs must be low while reset is held
        #2;
        vectors++;
        if (pulse_out !== '0 || busy !== '0 || done !== '0) begin
            miscompares++;
            $display("FAIL reset_state got p=%b b=%b d=%b exp all 0", pulse_out, busy, done);
        end
        #11 reset_n = 1'b1;
        for (int c = 0; c < 11; c++) begin
            trig[0] = (c != 4);
            pe = (c >= 5 && c <= 7);
            push_exp(oh(0, pe), oh(0, c == 8), oh(0, pe));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL reset_edge c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    task automatic test_oneshot();
        exp_t e;
        bit   pe;
        cfg_len[0 +: W] = 8'd5;
        cfg_mode[1:0]   = 2'b00;
        for (int c = 0; c < 24; c++) begin
            trig[0] = (c == 10 || c == 13 || c == 16);
            pe = (c >= 10 && c <= 14) || (c >= 16 && c <= 20);
            push_exp(oh(0, pe), oh(0, c == 15 || c == 21), oh(0, pe));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL oneshot c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    task automatic test_retrig();
        exp_t e;
        bit   pe;
        cfg_len[1*W +: W] = 8'd4;
        cfg_mode[3:2]     = 2'b01;
        // third event lands in the last HIGH cycle and must extend seamlessly
        for (int c = 0; c < 15; c++) begin
            trig[1] = (c == 1 || c == 4 || c == 8);
            pe = (c >= 1 && c <= 11);
            push_exp(oh(1, pe), oh(1, c == 12), oh(1, pe));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL retrig c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    task automatic test_periodic();
        exp_t e;
        bit   pe;
        cfg_len[2*W +: W] = 8'd3;
        cfg_mode[5:4]     = 2'b10;
        for (int c = 0; c < 14; c++) begin
            trig[2] = (c == 1 || c == 5);
            stop[2] = (c == 9);
            pe = (c >= 1 && c <= 3) || (c >= 7 && c <= 8);
            push_exp(oh(2, pe), '0, oh(2, c >= 1 && c <= 8));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL periodic c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
        stop = '0;
    endtask

    task automatic test_len0();
        exp_t e;
        cfg_len[0 +: W] = 8'd0;
        cfg_mode[1:0]   = 2'b00;
        for (int c = 0; c < 5; c++) begin
            trig[0] = (c == 1);
            push_exp('0, '0, '0);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL len0 c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    task automatic test_max_len();
        exp_t e;
        bit   pe;
        cfg_len[0 +: W] = 8'd255;
        for (int c = 0; c < 259; c++) begin
            trig[0] = (c == 1);
            pe = (c >= 1 && c <= 255);
            push_exp(oh(0, pe), oh(0, c == 256), oh(0, pe));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL max_len c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    task automatic test_stop();
        exp_t e;
        bit   pe;
        cfg_len[1*W +: W] = 8'd3;
        cfg_mode[3:2]     = 2'b00;
        for (int c = 0; c < 21; c++) begin
            trig[1] = (c == 1 || c == 4 || c == 10 || c == 16);
            stop[1] = (c == 1 || c == 6 || c == 13);
            pe = (c >= 4 && c <= 5) || (c >= 10 && c <= 12) || (c >= 16 && c <= 18);
            push_exp(oh(1, pe), oh(1, c == 19), oh(1, pe));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL stop c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
        stop = '0;
    endtask

    task automatic test_cfg_change();
        exp_t e;
        bit   pe;
        cfg_len[3*W +: W] = 8'd6;
        cfg_mode[7:6]     = 2'b00;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) cfg_len[3*W +: W] = 8'd2;
            trig[3] = (c == 1 || c == 10);
            pe = (c >= 1 && c <= 6) || (c >= 10 && c <= 11);
            push_exp(oh(3, pe), oh(3, c == 7 || c == 12), oh(3, pe));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL cfg_change c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit   p1, p2;
        cfg_len[1*W +: W] = 8'd2;
        cfg_mode[3:2]     = 2'b10;
        cfg_len[2*W +: W] = 8'd10;
        cfg_mode[5:4]     = 2'b00;
        for (int c = 0; c < 6; c++) begin
            trig[1] = (c == 1);
            trig[2] = (c >= 2);
            p1 = (c == 1 || c == 2 || c == 5);
            p2 = (c >= 2);
            push_exp(oh(1, p1) | oh(2, p2), '0, oh(1, c >= 1) | oh(2, p2));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL async_pre c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        // assert reset between edges: outputs must clear without a clock edge
        reset_n = 1'b0;
        #2;
        vectors++;
        if (pulse_out !== '0 || busy !== '0 || done !== '0) begin
            miscompares++;
            $display("FAIL async_clear got p=%b b=%b d=%b exp all 0", pulse_out, busy, done);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 18; c++) begin
            trig[2] = (c != 5);
            p2 = (c >= 6 && c <= 15);
            push_exp(oh(2, p2), oh(2, c == 16), oh(2, p2));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (pulse_out !== e.p || done !== e.d || busy !== e.b) begin
                miscompares++;
                $display("FAIL async_post c=%0d got p=%b d=%b b=%b exp p=%b d=%b b=%b",
                         c, pulse_out, done, busy, e.p, e.d, e.b);
            end
        end
        trig = '0;
    endtask

    initial begin
        reset_n         = 1'b0;
        cfg_len         = '0;
        cfg_mode        = '0;
        stop            = '0;
        trig            = 4'b0001;
        cfg_len[0 +: W] = 8'd3;
        test_reset();
        test_oneshot();
        test_retrig();
        test_periodic();
        test_len0();
        test_max_len();
        test_stop();
        test_cfg_change();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, parametrised pulse generator for F-NIC control paths. It stretches trigger events into pulses whose length is set per channel at run time, with one-shot, retriggerable and periodic modes. Each channel has its own abort input and completion strobe. It sits between control/CSR logic and downstream consumers that need a clean, fixed-length enable, for example timeouts, LED/heartbeat and flush windows.

## Interface
Parameters:
- `N_CH`, 4: number of independent channels (1..32).
- `CNT_WIDTH`, 8: width of the per-channel length field; maximum pulse length is 2^CNT_WIDTH−1 cycles.
- `EDGE_TRIG`, 1: 1 = trigger on rising edge of `trig[i]`; 0 = trigger on level (every high cycle is a trigger event).

Ports:
- `clk`  in  1  single clock; all logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_len`  in  N_CH*CNT_WIDTH  per-channel pulse length in cycles; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- `cfg_mode`  in  N_CH*2  per-channel mode: 00 ONESHOT, 01 RETRIG, 10 PERIODIC, 11 reserved (behaves as ONESHOT).
- `trig`  in  N_CH  trigger inputs.
- `stop`  in  N_CH  abort; returns the channel to IDLE.
- `pulse_out`  out  N_CH  generated pulses; registered.
- `busy`  out  N_CH  channel not in IDLE; registered.
- `done`  out  N_CH  one-cycle strobe on natural pulse end; registered.

## Operation
- Trigger event `ev[i]`:
  - EDGE_TRIG=1: `trig[i] & ~trig_q[i]`, where `trig_q` is a one-cycle delay of `trig`.
  - EDGE_TRIG=0: `trig[i]`.
- Each channel has three states, IDLE, HIGH and LOW, plus a down-counter `cnt` of CNT_WIDTH bits.
- Length and mode are snapshotted at the accepting event. Later `cfg_*` changes do not affect a running pulse.
- IDLE:
  - `ev` with `cfg_len != 0` → HIGH, `cnt <= cfg_len-1`, latch mode.
  - `ev` with `cfg_len == 0` → ignored; no pulse, no `done`.
- HIGH, when `cnt == 0`:
  - ONESHOT/RETRIG → IDLE with `done` asserted.
  - PERIODIC → LOW with `cnt <= len-1`.
- HIGH, when `cnt != 0`: decrement `cnt`.
- HIGH, event handling by latched mode:
  - RETRIG: `ev` reloads `cnt <= len-1` (the latched len). The pulse stays continuously high and no `done` is issued for the truncated interval.
  - ONESHOT/PERIODIC: `ev` is ignored.
- LOW (PERIODIC only):
  - `cnt == 0` → HIGH, `cnt <= len-1`.
  - Otherwise decrement `cnt`.
  - `ev` is ignored.
  - PERIODIC never asserts `done`; it runs until `stop`.
- `stop[i]` in any state → IDLE next cycle, `cnt` cleared, no `done`. `stop` has priority over a simultaneous `ev` and over natural completion in the same cycle.
- Outputs: `pulse_out = (state == HIGH)`; `busy = (state != IDLE)`.

## Timing
- Reset (`reset_n` low, async):
  - State IDLE, `cnt` = 0.
  - `pulse_out`, `busy`, `done` = 0 immediately.
  - `trig_q` = all ones, so a trigger held high across reset release is not an edge.
- Latency: an event sampled at edge t gives `pulse_out` high from cycle t+1 through t+len, exactly len cycles.
- `done` is high in cycle t+len+1, the same cycle `pulse_out` falls, for exactly one cycle.
- ONESHOT back-to-back: an event in the cycle `done` is high is accepted, so there is a minimum 1-cycle low gap between pulses.
- RETRIG: an event in the last HIGH cycle extends the pulse seamlessly; no `done` and no low gap.
- PERIODIC: period is 2*len, 50 % duty; the first HIGH starts at t+1.
- Channels are fully independent; no cross-channel interaction.

## Structure
- Package `pulse_gen_pkg`:
  - `pg_mode_e` (ONESHOT, RETRIG, PERIODIC, RSVD), 2-bit.
  - `pg_state_e` (IDLE, HIGH, LOW).
- Sub-module `pulse_gen_ch`: one channel covering edge detect, FSM and counter. It is instantiated N_CH times in a generate loop.
- The top level only slices the buses.

## Test plan
- Reset/edge: hold `trig[0]`=1 through `reset_n` release → no pulse. Drop it and raise it again at t → `pulse_out[0]` high t+1..t+len.
- ONESHOT, len=5:
  - Event at t=10 → `pulse_out` high cycles 11–15, `done` at 16.
  - Second event at 13 → ignored.
  - Event at 16 → pulse 17–21.
- RETRIG, len=4: events at t=0 and t=3 → `pulse_out` high 1–7 continuously, single `done` at 8.
- PERIODIC, len=3: event at 0 → high 1–3, low 4–6, high 7–9… `stop` at 8 → `pulse_out`=0 from 9, no `done`.
- Boundaries:
  - len=0 event → nothing happens.
  - len=2^CNT_WIDTH−1 → full-length pulse.
  - `stop` and `ev` in the same IDLE cycle → stays IDLE.
  - `cfg_len` changed mid-pulse → old length kept.
- Async reset mid-pulse on channel 2, with channel 1 running periodic → all outputs 0 without waiting for a clock edge. After release there is no activity until a new edge.
